// File: rtl/uart_pkg.sv
// Shared UART definitions: default system/baud rates, a constant-foldable
// clog2 and the reset-time increment calculation for the fractional baud
// generator. Used by the baud generator and the uart_rx/uart_tx cores.
`timescale 1ns/1ps
package uart_pkg;

  // System defaults shared by every UART core
  localparam int unsigned UART_CLOCK_HZ = 25000000;
  localparam int unsigned UART_BAUD     = 9600;

  // Per-edge action of the phase accumulator, decoded from restart/enable
  typedef enum logic [1:0] {
    MODE_HOLD    = 2'd0,
    MODE_RUN     = 2'd1,
    MODE_RESTART = 2'd2
  } acc_mode_e;

  // Ceiling log2, usable in parameter expressions (clog2(1) = 0)
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  // Rounded fractional increment: BAUD*OVERSAMPLE/CLOCK scaled by 2^ACCWIDTH.
  // The guard bits keep the rounding bias below half an LSB. 64-bit maths
  // avoids overflow for high baud rates or wide accumulators.
  function automatic longint unsigned calc_baud_inc(
    input longint unsigned clock,
    input longint unsigned baud,
    input longint unsigned oversample,
    input longint unsigned accwidth,
    input longint unsigned roundbits
  );
    longint unsigned numer;
    longint unsigned denom;
    numer = ((baud * oversample) << (accwidth - (roundbits - 1))) + (clock >> roundbits);
    denom = clock >> (roundbits - 1);
    return numer / denom;
  endfunction

endpackage

// File: rtl/uart_baudgen_prog_if.sv
// Control/status bundle of the programmable baud generator. The master side
// (UART controller) programs the rate and restarts the phase; the slave side
// (the generator) returns the tick streams, the phase and the clamp flag.
`timescale 1ns/1ps
interface uart_baudgen_prog_if #(
  parameter int unsigned ACCWIDTH = 16,
  parameter int unsigned CW       = 4
);

  logic                enable;
  logic                inc_load;
  logic [ACCWIDTH:0]   inc_value;
  logic                restart;
  logic [CW-1:0]       restart_phase;
  logic                tick_os;
  logic                tick;
  logic [CW-1:0]       phase;
  logic                inc_clamped;

  modport master (
    output enable,
    output inc_load,
    output inc_value,
    output restart,
    output restart_phase,
    input  tick_os,
    input  tick,
    input  phase,
    input  inc_clamped
  );

  modport slave (
    input  enable,
    input  inc_load,
    input  inc_value,
    input  restart,
    input  restart_phase,
    output tick_os,
    output tick,
    output phase,
    output inc_clamped
  );

endinterface

// File: rtl/uart_tick_divider.sv
// Oversample phase counter: counts accumulator carries modulo OVERSAMPLE and
// emits a registered bit tick on the carry that wraps the count. A restart
// reloads the phase so the receiver can align to a start-bit edge.
`timescale 1ns/1ps
module uart_tick_divider
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned CW         = clog2(OVERSAMPLE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_carry,
  input  logic          i_restart,
  input  logic [CW-1:0] i_restart_phase,
  output logic          o_tick,
  output logic [CW-1:0] o_phase
);

  localparam logic [CW-1:0] LAST_PHASE = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic [CW-1:0] w_cnt_next;
  logic          w_tick_next;
  logic          w_last;

  assign w_last = (r_cnt == LAST_PHASE);

  // Next phase/tick: restart wins over a carry; no carry means no tick
  always_comb begin
    w_cnt_next  = r_cnt;
    w_tick_next = 1'b0;
    if (i_restart) begin
      w_cnt_next  = i_restart_phase;
      w_tick_next = 1'b0;
    end else if (i_carry) begin
      w_cnt_next  = w_last ? '0 : r_cnt + CW'(1);
      w_tick_next = w_last;
    end
  end

  // Phase counter and bit-tick register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_tick <= w_tick_next;
    end
  end

  assign o_tick  = r_tick;
  assign o_phase = r_cnt;

endmodule

// File: rtl/uart_baudgen_prog.sv
// Runtime-programmable fractional baud generator. A phase accumulator adds
// the increment every enabled clock; each carry out is an oversample tick and
// every OVERSAMPLE-th carry is a bit tick. The increment can be reloaded at
// any time without disturbing the accumulator, and the generator can be
// phase-restarted to align to an incoming start bit.
`timescale 1ns/1ps
module uart_baudgen_prog
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK      = UART_CLOCK_HZ,
  parameter int unsigned BAUD       = UART_BAUD,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned ACCWIDTH   = 16,
  parameter int unsigned ROUNDBITS  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_baudgen_prog_if.slave bus
);

  localparam int unsigned CW = clog2(OVERSAMPLE);
  localparam logic [ACCWIDTH-1:0] DEFAULT_INC =
    ACCWIDTH'(calc_baud_inc(64'(CLOCK), 64'(BAUD), 64'(OVERSAMPLE),
                            64'(ACCWIDTH), 64'(ROUNDBITS)));

  // Architectural state
  logic [ACCWIDTH-1:0] r_acc;
  logic [ACCWIDTH-1:0] r_inc;
  logic                r_tick_os;
  logic                r_clamp;

  // Combinational next-state
  acc_mode_e           w_mode;
  logic [ACCWIDTH:0]   w_sum_full;
  logic                w_carry;
  logic [ACCWIDTH-1:0] w_acc_next;
  logic                w_tick_os_next;
  logic                w_div_carry;
  logic [ACCWIDTH-1:0] w_inc_next;
  logic                w_clamp_next;
  logic                w_tick;
  logic [CW-1:0]       w_phase;

  // One extra bit holds the carry; inc_r < 2^ACCWIDTH so at most one carry
  assign w_sum_full = {1'b0, r_acc} + {1'b0, r_inc};
  assign w_carry    = w_sum_full[ACCWIDTH];

  // Decode the per-edge action: restart has priority over enable
  always_comb begin
    w_mode = MODE_HOLD;
    if (bus.restart) begin
      w_mode = MODE_RESTART;
    end else if (bus.enable) begin
      w_mode = MODE_RUN;
    end
  end

  // Accumulator next value and oversample tick for the decoded action
  always_comb begin
    w_acc_next     = r_acc;
    w_tick_os_next = 1'b0;
    w_div_carry    = 1'b0;
    case (w_mode)
      MODE_RESTART: begin
        w_acc_next = '0;
      end
      MODE_RUN: begin
        w_acc_next     = w_sum_full[ACCWIDTH-1:0];
        w_tick_os_next = w_carry;
        w_div_carry    = w_carry;
      end
      default: begin
        // Disabled: fractional phase is preserved, no ticks
        w_acc_next = r_acc;
      end
    endcase
  end

  // Increment reload, independent of restart/enable; out-of-range saturates
  always_comb begin
    w_inc_next   = r_inc;
    w_clamp_next = r_clamp;
    if (bus.inc_load) begin
      if (bus.inc_value[ACCWIDTH]) begin
        w_inc_next   = '1;
        w_clamp_next = 1'b1;
      end else begin
        w_inc_next   = bus.inc_value[ACCWIDTH-1:0];
        w_clamp_next = 1'b0;
      end
    end
  end

  // Accumulator, increment, oversample tick and clamp flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_inc     <= DEFAULT_INC;
      r_tick_os <= 1'b0;
      r_clamp   <= 1'b0;
    end else begin
      r_acc     <= w_acc_next;
      r_inc     <= w_inc_next;
      r_tick_os <= w_tick_os_next;
      r_clamp   <= w_clamp_next;
    end
  end

  // Phase counter; only sees carries from edges that actually ran
  uart_tick_divider #(
    .OVERSAMPLE (OVERSAMPLE),
    .CW         (CW)
  ) u_tick_divider (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_carry         (w_div_carry),
    .i_restart       (bus.restart),
    .i_restart_phase (bus.restart_phase),
    .o_tick          (w_tick),
    .o_phase         (w_phase)
  );

  assign bus.tick_os     = r_tick_os;
  assign bus.tick        = w_tick;
  assign bus.phase       = w_phase;
  assign bus.inc_clamped = r_clamp;

endmodule
